// File: rtl/spi_baud_generator.sv
// spi_baud_generator: SCLK divider with per-edge sample/shift strobes for the SPI master.
module spi_baud_generator #(
  parameter int DIV_W = 12
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [1:0]       spi_mode_i,
  input  logic             spiswai_i,
  input  logic [2:0]       sppr_i,
  input  logic [2:0]       spr_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic             ss_i,
  output logic             sclk_o,
  output logic             sample_flag_o,
  output logic             shift_flag_o,
  output logic [DIV_W-1:0] BaudRateDivisor_o
);
  logic [DIV_W-1:0] cnt, half;
  logic active, toggle, leading;
  assign half = (DIV_W'(sppr_i) + DIV_W'(1)) << spr_i;
  assign BaudRateDivisor_o = half << 1;
  assign active = ~ss_i & (spi_mode_i == 2'b00 | (spi_mode_i == 2'b01 & ~spiswai_i));
  // >= rather than == so a mid-transfer rate reduction toggles at once instead of wrapping
  assign toggle = active & (cnt >= half - DIV_W'(1));
  assign leading = sclk_o == cpol_i;
  assign sample_flag_o = toggle & (leading ^ cpha_i);
  assign shift_flag_o = toggle & ~(leading ^ cpha_i);
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt <= '0;
      sclk_o <= 1'b0;
    end else if (!active) begin
      cnt <= '0;
      sclk_o <= cpol_i;
    end else if (toggle) begin
      cnt <= '0;
      sclk_o <= ~sclk_o;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end
endmodule

// File: tb/tb_spi_baud_generator.sv
// tb_spi_baud_generator: cycle-level model check plus directed literal checks of the SPI baud generator.
module tb_spi_baud_generator;
  logic PCLK = 0, PRESET = 1;
  logic [1:0] spi_mode_i = 0;
  logic spiswai_i = 0, cpol_i = 0, cpha_i = 0, ss_i = 1;
  logic [2:0] sppr_i = 1, spr_i = 0;
  logic sclk_o, sample_flag_o, shift_flag_o;
  logic [11:0] BaudRateDivisor_o;
  int n_checks = 0, n_fail = 0, n_samp = 0, n_shift = 0;
  int s0, h0;
  int m_el = 0;
  bit m_sclk = 0;

  spi_baud_generator #(.DIV_W(12)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .spi_mode_i(spi_mode_i), .spiswai_i(spiswai_i),
    .sppr_i(sppr_i), .spr_i(spr_i), .cpol_i(cpol_i), .cpha_i(cpha_i), .ss_i(ss_i),
    .sclk_o(sclk_o), .sample_flag_o(sample_flag_o), .shift_flag_o(shift_flag_o),
    .BaudRateDivisor_o(BaudRateDivisor_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: m_el counts PCLK cycles since activation or the last SCLK edge;
  // an edge is due once m_el+1 reaches half a period.
  always @(negedge PCLK) begin : cmp
    int h;
    bit act, tog, lead;
    h = (int'(sppr_i) + 1) << spr_i;
    act = !ss_i && (spi_mode_i == 2'b00 || (spi_mode_i == 2'b01 && !spiswai_i));
    n_samp += int'(sample_flag_o);
    n_shift += int'(shift_flag_o);
    chk("divisor", int'(BaudRateDivisor_o), 2 * h);
    if (PRESET) begin
      m_sclk = 0;
      m_el = 0;
      chk("rst_sclk", int'(sclk_o), 0);
      chk("rst_sample", int'(sample_flag_o), 0);
      chk("rst_shift", int'(shift_flag_o), 0);
    end else begin
      tog = act && (m_el + 1 >= h);
      lead = (m_sclk == cpol_i);
      chk("sclk", int'(sclk_o), int'(m_sclk));
      chk("sample", int'(sample_flag_o), int'(tog && (lead != cpha_i)));
      chk("shift", int'(shift_flag_o), int'(tog && (lead == cpha_i)));
      if (!act) begin
        m_sclk = cpol_i;
        m_el = 0;
      end else if (tog) begin
        m_sclk = !m_sclk;
        m_el = 0;
      end else m_el++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    tick(2);
    PRESET = 0;
    tick(2);
    chk("idle_sclk", int'(sclk_o), 0);
    // async reset mid-transfer, half=2: after 3 edges sclk=1 and a trailing shift pulse is live
    ss_i = 0;
    tick(3);
    chk("pre_rst_sclk", int'(sclk_o), 1);
    chk("pre_rst_shift", int'(shift_flag_o), 1);
    PRESET = 1;
    #1;
    chk("async_sclk", int'(sclk_o), 0);
    chk("async_shift", int'(shift_flag_o), 0);
    chk("async_sample", int'(sample_flag_o), 0);
    chk("div_in_reset", int'(BaudRateDivisor_o), 4);
    tick(2);
    PRESET = 0;
    ss_i = 1;
    tick(2);
    // 16 active cycles at divisor 4, cpol=0 cpha=0
    ss_i = 0;
    s0 = n_samp; h0 = n_shift;
    chk("c0_sample", int'(sample_flag_o), 0);
    tick(1);
    chk("c1_sclk", int'(sclk_o), 0);
    chk("c1_sample", int'(sample_flag_o), 1);
    tick(1);
    chk("first_rise", int'(sclk_o), 1);
    tick(1);
    chk("c3_shift", int'(shift_flag_o), 1);
    tick(13);
    chk("n_sample_div4", n_samp - s0, 4);
    chk("n_shift_div4", n_shift - h0, 4);
    ss_i = 1;
    // divisor 2, cpol=1 cpha=1
    sppr_i = 0; cpol_i = 1; cpha_i = 1;
    tick(2);
    chk("div2", int'(BaudRateDivisor_o), 2);
    chk("idle_hi", int'(sclk_o), 1);
    ss_i = 0;
    s0 = n_samp; h0 = n_shift;
    #1;
    chk("lead_shift", int'(shift_flag_o), 1);
    tick(1);
    chk("fall", int'(sclk_o), 0);
    chk("trail_sample", int'(sample_flag_o), 1);
    tick(7);
    chk("n_sample_div2", n_samp - s0, 4);
    chk("n_shift_div2", n_shift - h0, 4);
    ss_i = 1;
    // max divisor, then a mid-transfer rate reduction
    sppr_i = 7; spr_i = 7; cpol_i = 0; cpha_i = 0;
    tick(2);
    chk("div2048", int'(BaudRateDivisor_o), 2048);
    ss_i = 0;
    tick(1023);
    chk("no_edge_1023", int'(sclk_o), 0);
    tick(1);
    chk("edge_1024", int'(sclk_o), 1);
    tick(500);
    spr_i = 0;
    #1;
    chk("div16", int'(BaudRateDivisor_o), 16);
    tick(1);
    chk("fast_toggle", int'(sclk_o), 0);
    tick(7);
    chk("pre_16_edge", int'(sclk_o), 0);
    tick(1);
    chk("half8_rise", int'(sclk_o), 1);
    tick(8);
    chk("half8_fall", int'(sclk_o), 0);
    ss_i = 1;
    // wait mode stop and resume
    sppr_i = 1; spr_i = 0; spi_mode_i = 2'b01; spiswai_i = 0;
    tick(2);
    ss_i = 0;
    tick(3);
    chk("wait_run_sclk", int'(sclk_o), 1);
    spiswai_i = 1;
    s0 = n_samp; h0 = n_shift;
    tick(1);
    chk("wait_stop_sclk", int'(sclk_o), 0);
    tick(3);
    chk("wait_stop_flags", (n_samp - s0) + (n_shift - h0), 0);
    spiswai_i = 0;
    tick(1);
    chk("resume_c1", int'(sclk_o), 0);
    tick(1);
    chk("resume_rise", int'(sclk_o), 1);
    // reserved mode never runs
    spi_mode_i = 2'b10;
    s0 = n_samp; h0 = n_shift;
    tick(8);
    chk("mode10_sclk", int'(sclk_o), 0);
    chk("mode10_flags", (n_samp - s0) + (n_shift - h0), 0);
    // ss rises in a toggle cycle
    spi_mode_i = 2'b00;
    ss_i = 1;
    tick(2);
    ss_i = 0;
    tick(1);
    chk("tog_sample", int'(sample_flag_o), 1);
    ss_i = 1;
    #1;
    chk("ssrise_sample", int'(sample_flag_o), 0);
    chk("ssrise_shift", int'(shift_flag_o), 0);
    tick(1);
    chk("ssrise_sclk", int'(sclk_o), 0);
    // cpol change while idle appears one cycle later
    cpol_i = 1;
    #1;
    chk("cpol_hold", int'(sclk_o), 0);
    tick(1);
    chk("cpol_follow", int'(sclk_o), 1);
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_baud_generator.md
# spi_baud_generator

Generates the SPI serial clock and the per-edge sample/shift strobes for the master datapath. Computes the baud-rate divisor from the prescaler fields, publishes it to the slave-select stage, and runs whenever that stage drives `ss_i` low in an enabled mode. Its strobes drive the shift register that moves MOSI/MISO bits.

## Interface
- `DIV_W`, default 12: width of the divisor and edge counter. Must hold (7+1)<<8 = 2048.
- `PCLK` in 1: system clock; all state is updated on the rising edge.
- `PRESET` in 1: asynchronous reset, active-high.
- `spi_mode_i` in 2: 00 run, 01 wait, 10/11 reserved (treated as stopped).
- `spiswai_i` in 1: stop-in-wait; in mode 01, a value of 1 stops SCLK.
- `sppr_i` in 3: prescaler (SPPR).
- `spr_i` in 3: rate select (SPR).
- `cpol_i` in 1: SCLK idle level.
- `cpha_i` in 1: clock phase.
- `ss_i` in 1: slave select from the slave-select stage, active-low.
- `sclk_o` out 1: serial clock, registered.
- `sample_flag_o` out 1: one-PCLK pulse; MISO is sampled at the rising PCLK edge that ends this cycle.
- `shift_flag_o` out 1: one-PCLK pulse; MOSI is shifted at the rising PCLK edge that ends this cycle.
- `BaudRateDivisor_o` out DIV_W: (sppr_i+1) << (spr_i+1), combinational; feeds the slave-select stage.

## Operation
- **Divisor:** BaudRateDivisor_o = (sppr_i+1)·2^(spr_i+1). The range is 2 to 2048, computed at DIV_W bits with no overflow.
- **Half period:** half = BaudRateDivisor_o>>1 = (sppr_i+1)<<spr_i, in PCLK cycles.
- **active** = ~ss_i & (spi_mode_i==00 | (spi_mode_i==01 & ~spiswai_i)).
- **Counter `cnt`** (DIV_W bits):
  - When not active, the next value is 0.
  - When active and cnt >= half-1 ("toggle cycle"), the next value is 0 and sclk_o inverts.
  - Otherwise cnt increments by 1.
  - The `>=` comparison makes a mid-transfer reduction of sppr_i/spr_i take effect at once, with no wrap through 2^DIV_W.
- **Idle level:** when not active, sclk_o is loaded with cpol_i each cycle. A cpol_i change while idle therefore appears one cycle later. While active, cpol_i changes are ignored.
- **Edge classification:** in a toggle cycle, the edge is *leading* when sclk_o==cpol_i and *trailing* otherwise.
- **Flags:** the flags are combinational from the registered state and are only asserted in toggle cycles while active.
  - cpha_i=0: sample_flag_o on leading edges, shift_flag_o on trailing edges.
  - cpha_i=1: shift_flag_o on leading edges, sample_flag_o on trailing edges.
  - The two flags are never high in the same cycle.
- **Leaving active:** when ss_i rises or the mode stops, the generator goes idle on the next edge with no partial pulse completion. sclk_o returns to cpol_i, cnt returns to 0, and the flags drop in the same cycle that active drops.
- **Stop and resume:** a wait-mode stop (spiswai_i=1 in mode 01) behaves exactly like ss_i high. On resume, counting restarts from cnt=0.

## Timing
- **Reset values:** cnt=0, sclk_o=0, sample_flag_o=0, shift_flag_o=0. BaudRateDivisor_o follows its inputs even during reset.
- **After reset:** the first clock edge with PRESET low loads sclk_o=cpol_i if not active.
- **First edge:** if ss_i is sampled low in cycle 0 (cnt=0), the first toggle cycle is cycle half-1. sclk_o changes at the end of that cycle, so the first SCLK edge is visible `half` cycles after active.
- **Steady state:** the SCLK period is BaudRateDivisor_o PCLK cycles with 50% duty. Each flag pulses once per SCLK period and is exactly 1 PCLK wide. With half=1 the flags alternate every cycle.
- **Reset mid-transfer:** PRESET asynchronously forces the reset values immediately, independent of PCLK.
- **Simultaneous events:** if ss_i rises in a toggle cycle, the cycle is no longer a toggle cycle because active is already 0. No flag is emitted and sclk_o goes to cpol_i.

## Test plan
- Reset with PRESET=1 mid-transfer -> sclk_o, both flags and cnt go to 0 asynchronously. BaudRateDivisor_o tracks sppr_i=1, spr_i=0 as 4.
- sppr_i=1, spr_i=0, cpol_i=0, cpha_i=0, mode 00, ss_i low for 16 cycles:
  - sclk_o toggles every 2 cycles (period 4), first rising edge 2 cycles after ss_i low.
  - sample_flag_o pulses in the cycle before each rising edge, shift_flag_o before each falling edge.
  - Exactly 4 pulses of each.
- sppr_i=0, spr_i=0, cpol_i=1, cpha_i=1 -> divisor 2; sclk_o idles 1 and toggles every cycle. shift_flag_o precedes each falling (leading) edge and sample_flag_o each rising edge.
- sppr_i=7, spr_i=7 -> BaudRateDivisor_o=2048; the first sclk_o edge comes 1024 cycles after ss_i low with no counter wrap. Then change spr_i to 0 at cnt=500 -> a toggle on the next cycle, followed by a period of 16.
- Mode 01 with spiswai_i toggled 0->1 mid-transfer -> sclk_o returns to cpol_i the next cycle and flags stay 0. Back to 0 -> counting restarts from cnt=0. Mode 10 with ss_i low -> no toggling.
- ss_i deasserted in a toggle cycle -> no flag in that cycle and sclk_o goes to cpol_i. cpol_i flipped while idle -> sclk_o follows one cycle later.
